sfft_frame_readout: RTL and testbench

Double-buffered snapshot and readout block between the SFFT pipeline output stream and the software-facing byte bus. It captures one complete spectrum frame into a back bank. On frame completion it swaps the back bank to the front bank, unless software holds the read lock. It then serves the bins, frame timestamp, overrun count and status as little-endian 32-bit-word byte reads. It generalises the single-register readout with parametrised bin count and width, a hold/lock handshake, drop accounting and malformed-frame detection.

---
 rtl/sfft_frame_readout.sv | 186 ++++++++++++++++++
 tb/tb_sfft_frame_readout.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfft_frame_readout.sv
// sfft_frame_readout
//   Double-buffered snapshot of one SFFT spectrum frame with a byte-wide
//   software read port. Bins stream into the back bank. A well-formed frame
//   end swaps the banks and publishes a timestamp, unless software holds the
//   read lock. In that case the frame is dropped and counted as an overrun.
//   A frame of the wrong length sets a sticky error flag.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   bin_valid    bin_data valid this cycle
//   bin_data     bin magnitude, index order from 0
//   bin_last     final bin of a frame (qualified by bin_valid)
//   chipselect   bus select
//   write        bus write strobe
//   read         bus read strobe
//   address      byte address
//   writedata    bus write byte
//   readdata     registered bus read byte (latency 1, held between reads)
//   frame_ready  an unread frame is published in the front bank
//
// Register map (word W = address[ADDR_WIDTH-1:2], lane = address[1:0])
//   W <  N    front-bank bin W, zero-extended to 32 bits
//   W == N    published frame timestamp
//   W == N+1  overrun counter
//   W == N+2  lane 0: {5'b0, error, lock, frame_ready}; write bit0 = lock
//   others    read as 0
module sfft_frame_readout #(
  parameter int N_BINS_LOG2 = 9,
  parameter int BIN_WIDTH   = 32,
  parameter int TIME_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bin_valid,
  input  logic [BIN_WIDTH-1:0]  bin_data,
  input  logic                  bin_last,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            writedata,
  output logic [7:0]            readdata,
  output logic                  frame_ready
);

  localparam int N_BINS = 1 << N_BINS_LOG2;
  localparam int WW     = ADDR_WIDTH - 2;

  localparam logic [WW-1:0]          W_TS       = WW'(N_BINS);
  localparam logic [WW-1:0]          W_OVR      = WW'(N_BINS + 1);
  localparam logic [WW-1:0]          W_STAT     = WW'(N_BINS + 2);
  localparam logic [N_BINS_LOG2-1:0] IDX_LAST   = '1;

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [BIN_WIDTH-1:0]   r_bank [0:2*N_BINS-1];

  logic [7:0]             r_readdata;
  logic                   r_frame_ready;
  logic                   r_lock;
  logic                   r_error;
  logic                   r_front_sel;
  logic [N_BINS_LOG2-1:0] r_wr_idx;
  // Set once the write index has moved past the last bin. It blocks further
  // writes and marks the frame as malformed when it ends.
  logic                   r_ovf;
  logic [TIME_WIDTH-1:0]  r_frame_cnt;
  logic [TIME_WIDTH-1:0]  r_ts;
  logic [31:0]            r_ovr;

  logic [WW-1:0]          w_word;
  logic [1:0]             w_lane;
  logic                   w_rd_strobe;
  logic                   w_ctrl_wr;
  logic                   w_frame_end;
  logic                   w_frame_good;
  logic                   w_frame_bad;
  logic                   w_lock_eff;
  logic                   w_bank_we;
  logic [TIME_WIDTH-1:0]  w_cnt_next;
  logic [31:0]            w_rd_word;
  logic [7:0]             w_rd_byte;
  logic                   w_unused;

  assign w_word      = address[ADDR_WIDTH-1:2];
  assign w_lane      = address[1:0];
  assign w_rd_strobe = chipselect && read;
  assign w_ctrl_wr   = chipselect && write && (w_word == W_STAT) && (w_lane == 2'd0);

  assign w_frame_end  = bin_valid && bin_last;
  assign w_frame_good = w_frame_end && (r_wr_idx == IDX_LAST) && !r_ovf;
  assign w_frame_bad  = w_frame_end && !((r_wr_idx == IDX_LAST) && !r_ovf);
  assign w_cnt_next   = r_frame_cnt + 1'b1;

  // A control write in the same cycle as a frame end is applied first. The
  // frame therefore sees the lock value being written, not the old one.
  assign w_lock_eff = w_ctrl_wr ? writedata[0] : r_lock;

  assign w_bank_we = bin_valid && !r_ovf;

  // Only bit 0 of the control byte carries meaning.
  assign w_unused = ^writedata[7:1];

  always_ff @(posedge clk) begin
    if (w_bank_we) begin
      r_bank[{~r_front_sel, r_wr_idx}] <= bin_data;
    end
  end

  always_comb begin
    w_rd_word = 32'd0;
    if (w_word < W_TS) begin
      w_rd_word = 32'(r_bank[{r_front_sel, w_word[N_BINS_LOG2-1:0]}]);
    end else if (w_word == W_TS) begin
      w_rd_word = 32'(r_ts);
    end else if (w_word == W_OVR) begin
      w_rd_word = r_ovr;
    end else if (w_word == W_STAT && w_lane == 2'd0) begin
      w_rd_word = {24'd0, 5'd0, r_error, r_lock, r_frame_ready};
    end
  end

  assign w_rd_byte = w_rd_word[8*w_lane +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata    <= 8'd0;
      r_frame_ready <= 1'b0;
      r_lock        <= 1'b0;
      r_error       <= 1'b0;
      r_front_sel   <= 1'b0;
      r_wr_idx      <= '0;
      r_ovf         <= 1'b0;
      r_frame_cnt   <= '0;
      r_ts          <= '0;
      r_ovr         <= 32'd0;
    end else begin
      if (w_rd_strobe) begin
        r_readdata <= w_rd_byte;
      end

      if (bin_valid) begin
        if (bin_last) begin
          r_wr_idx <= '0;
          r_ovf    <= 1'b0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
          if (r_wr_idx == IDX_LAST) begin
            r_ovf <= 1'b1;
          end
        end
      end

      if (w_ctrl_wr) begin
        r_lock <= writedata[0];
        if (!writedata[0]) begin
          r_frame_ready <= 1'b0;
          r_error       <= 1'b0;
        end
      end

      // Later assignments override the control-write clears above.
      if (w_frame_good) begin
        r_frame_cnt <= w_cnt_next;
        if (w_lock_eff) begin
          if (r_ovr != 32'hFFFF_FFFF) begin
            r_ovr <= r_ovr + 32'd1;
          end
        end else begin
          r_front_sel   <= ~r_front_sel;
          r_ts          <= w_cnt_next;
          r_frame_ready <= 1'b1;
        end
      end

      if (w_frame_bad) begin
        r_error <= 1'b1;
      end
    end
  end

  assign readdata    = r_readdata;
  assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_sfft_frame_readout.sv
module tb_sfft_frame_readout;

  localparam int BW = 24;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          bin_valid;
  logic [BW-1:0] bin_data;
  logic          bin_last;
  logic          chipselect;
  logic          write;
  logic          read;
  logic [AW-1:0] address;
  logic [7:0]    writedata;
  logic [7:0]    readdata;
  logic          frame_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       rd_seen = 1'b0;
  logic [7:0] mon_exp;
  string      mon_name;

  always #5 clk = ~clk;

  sfft_frame_readout #(
    .N_BINS_LOG2(2),
    .BIN_WIDTH  (BW),
    .TIME_WIDTH (32),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bin_valid  (bin_valid),
    .bin_data   (bin_data),
    .bin_last   (bin_last),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .frame_ready(frame_ready)
  );

  // Monitor: a read strobe seen at a rising edge means readdata carries the
  // answer; compare it on the following falling edge.
  always @(posedge clk) rd_seen <= chipselect && read && reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read readdata=%02h but nothing expected", readdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (readdata !== mon_exp) begin
          errors++;
          $display("FAIL %s readdata=%02h expected=%02h", mon_name, readdata, mon_exp);
        end else begin
          $display("ok   %s readdata=%02h", mon_name, readdata);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, act, exp);
    end else begin
      $display("ok   %s value=%0h", n, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic beat(input logic [BW-1:0] d, input logic last);
    bin_valid = 1'b1; bin_data = d; bin_last = last;
    tick();
    bin_valid = 1'b0; bin_last = 1'b0;
  endtask

  task automatic frame4(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] c, input logic [BW-1:0] d);
    beat(a, 1'b0);
    beat(b, 1'b0);
    beat(c, 1'b0);
    beat(d, 1'b1);
  endtask

  task automatic frame_n(input int n, input logic [BW-1:0] base);
    for (int i = 0; i < n; i++) begin
      beat(base + BW'(i), i == n - 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bin_valid = 1'b0; bin_data = '0; bin_last = 1'b0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_frame_ready", 32'(frame_ready), 32'd0);
    check("reset_readdata", 32'(readdata), 32'd0);
    reset = 1'b1;
    tick();

    // Basic frame publish
    frame4(24'h11, 24'h22, 24'h33, 24'h44);
    bus_read(16'd0,  8'h11, "bin0");
    bus_read(16'd4,  8'h22, "bin1");
    bus_read(16'd8,  8'h33, "bin2");
    bus_read(16'd12, 8'h44, "bin3");
    bus_read(16'd16, 8'h01, "ts_first");
    bus_read(16'd1,  8'h00, "bin0_lane1");
    bus_read(16'd20, 8'h00, "ovr_zero");
    bus_read(16'd24, 8'h01, "status_ready");
    bus_read(16'd25, 8'h00, "status_lane1");
    bus_read(16'd28, 8'h00, "unmapped");

    // Lock holds the front bank; frames are counted as overruns
    bus_write(16'd24, 8'h01);
    bus_read(16'd24, 8'h03, "status_locked");
    frame4(24'h51, 24'h52, 24'h53, 24'h54);
    frame4(24'h61, 24'h62, 24'h63, 24'h64);
    frame4(24'h71, 24'h72, 24'h73, 24'h74);
    bus_read(16'd0,  8'h11, "locked_bin0");
    bus_read(16'd12, 8'h44, "locked_bin3");
    bus_read(16'd16, 8'h01, "locked_ts");
    bus_read(16'd20, 8'h03, "ovr_three");
    bus_write(16'd24, 8'h00);
    bus_read(16'd24, 8'h00, "status_unlocked");
    frame4(24'hA1, 24'hA2, 24'hA3, 24'hA4);
    bus_read(16'd16, 8'h05, "ts_five");
    bus_read(16'd12, 8'hA4, "bin3_after_unlock");
    bus_read(16'd24, 8'h01, "status_ready2");

    // Malformed frames: short then long
    frame_n(3, 24'hE0);
    frame_n(6, 24'hF0);
    bus_read(16'd24, 8'h05, "status_error");
    bus_read(16'd16, 8'h05, "ts_after_bad");
    bus_read(16'd0,  8'hA1, "bin0_after_bad");
    bus_write(16'd24, 8'h00);
    bus_read(16'd24, 8'h00, "status_error_clr");

    // Lock release in the same cycle as the frame end
    bus_write(16'd24, 8'h01);
    beat(24'hB1, 1'b0);
    beat(24'hB2, 1'b0);
    beat(24'hB3, 1'b0);
    bin_valid = 1'b1; bin_data = 24'hB4; bin_last = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 16'd24; writedata = 8'h00;
    tick();
    bin_valid = 1'b0; bin_last = 1'b0; chipselect = 1'b0; write = 1'b0;
    bus_read(16'd24, 8'h01, "status_release_swap");
    bus_read(16'd16, 8'h06, "ts_release");
    bus_read(16'd12, 8'hB4, "bin3_release");

    // Lock set in the same cycle as the frame end
    beat(24'hD1, 1'b0);
    beat(24'hD2, 1'b0);
    beat(24'hD3, 1'b0);
    bin_valid = 1'b1; bin_data = 24'hD4; bin_last = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 16'd24; writedata = 8'h01;
    tick();
    bin_valid = 1'b0; bin_last = 1'b0; chipselect = 1'b0; write = 1'b0;
    bus_read(16'd12, 8'hB4, "bin3_lockset_drop");
    bus_read(16'd20, 8'h04, "ovr_four");
    bus_read(16'd24, 8'h03, "status_lockset");
    tick();
    tick();
    check("readdata_held", 32'(readdata), 32'h03);

    // Asynchronous reset mid-frame
    beat(24'hC8, 1'b0);
    beat(24'hC9, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_frame_ready", 32'(frame_ready), 32'd0);
    check("async_rst_readdata", 32'(readdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    frame4(24'hC1, 24'hC2, 24'hC3, 24'hC4);
    bus_read(16'd16, 8'h01, "ts_after_reset");
    bus_read(16'd4,  8'hC2, "bin1_after_reset");
    bus_read(16'd20, 8'h00, "ovr_after_reset");
    bus_read(16'd24, 8'h01, "status_after_reset");

    // 24-bit bin zero extension
    frame4(24'hABCDEF, 24'h000001, 24'h000002, 24'h000003);
    bus_read(16'd0, 8'hEF, "wide_lane0");
    bus_read(16'd1, 8'hCD, "wide_lane1");
    bus_read(16'd2, 8'hAB, "wide_lane2");
    bus_read(16'd3, 8'h00, "wide_lane3");
    bus_read(16'd16, 8'h02, "ts_two");

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
